// File: rtl/bypass_scoreboard.sv
// Bypass scoreboard: tracks in-flight results after issue, forwards the newest
// matching value to each operand read port, and raises a load-use stall.
module bypass_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREAD     = 2,
    parameter int DEPTH     = 3,
    parameter int LOAD_SLOT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_we,
    input  logic                    issue_is_load,
    input  logic [4:0]              issue_rd,
    input  logic [NREAD*5-1:0]      rd_index,
    input  logic [NREAD*XLEN-1:0]   rd_regval,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [XLEN-1:0]         mem_result,
    input  logic                    flush,
    output logic [NREAD*XLEN-1:0]   fwd_val,
    output logic                    stall,
    output logic [15:0]             stall_count
);

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            load;
        logic [4:0]      rd;
        logic [XLEN-1:0] value;
        logic            ready;
    } slot_t;

    slot_t           slots [DEPTH];
    slot_t           nxt   [DEPTH];
    logic [DEPTH-1:0] avail;
    logic [XLEN-1:0] avail_val [DEPTH];
    logic [NREAD-1:0] port_blocked;

    // Value an entry can supply this cycle: captured result, or the live ALU/memory bus.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            avail[k]     = slots[k].ready;
            avail_val[k] = slots[k].value;
            if (!slots[k].ready) begin
                if (k == 0 && !slots[k].load) begin
                    avail[k]     = 1'b1;
                    avail_val[k] = alu_result;
                end else if (k == LOAD_SLOT && slots[k].load) begin
                    avail[k]     = 1'b1;
                    avail_val[k] = mem_result;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        fwd_val      = rd_regval;
        port_blocked = '0;
        for (int i = 0; i < NREAD; i++) begin
            // Scan oldest to newest so the newest match overrides older ones.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slots[k].valid && slots[k].we && slots[k].rd != 5'd0 &&
                    slots[k].rd == rd_index[5*i +: 5]) begin
                    port_blocked[i]          = !avail[k];
                    fwd_val[i*XLEN +: XLEN]  = avail[k] ? avail_val[k]
                                                        : rd_regval[i*XLEN +: XLEN];
                end
            end
            if (rst) begin
                port_blocked[i]         = 1'b0;
                fwd_val[i*XLEN +: XLEN] = rd_regval[i*XLEN +: XLEN];
            end
        end
    end

    assign stall = issue_valid && !rst && (|port_blocked);

    // Next contents of the slot pipeline, including result capture on the way down.
    always_comb begin
        nxt[0]       = '0;
        nxt[0].valid = issue_valid && !stall && !flush;
        nxt[0].we    = issue_we;
        nxt[0].load  = issue_is_load;
        nxt[0].rd    = issue_rd;
        for (int k = 1; k < DEPTH; k++) begin
            nxt[k] = slots[k-1];
            if (flush) begin
                nxt[k].valid = 1'b0;
            end
            if (k == 1 && slots[0].valid && slots[0].we && !slots[0].load) begin
                nxt[k].value = alu_result;
                nxt[k].ready = 1'b1;
            end
            if (k == LOAD_SLOT + 1 && slots[LOAD_SLOT].valid && slots[LOAD_SLOT].load) begin
                nxt[k].value = mem_result;
                nxt[k].ready = 1'b1;
            end
        end
    end

    // NOTE: only the valid/ready control bits are reset; rd and value are
    // don't-care while valid=0, so the datapath storage carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k].valid <= 1'b0;
                slots[k].ready <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments let every slot shift from its
            // pre-edge neighbour in the same edge, independent of statement order.
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench for bypass_scoreboard: directed scenarios, a randomized run
// against an age-based reference model, and a stall-counter saturation run.
module tb_bypass_scoreboard;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 3;
    localparam int LOAD_SLOT = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Main instance: default geometry
    logic        iv, we, ld, fl, rs;
    logic [4:0]  rd;
    logic [9:0]  idx;
    logic [63:0] rv;
    logic [31:0] alu, mem;
    logic [63:0] fwd;
    logic        stall;
    logic [15:0] cnt;

    bypass_scoreboard #(.XLEN(XLEN), .NREAD(2), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT)) u_dut (
        .clk(clk), .rst(rs), .issue_valid(iv), .issue_we(we), .issue_is_load(ld),
        .issue_rd(rd), .rd_index(idx), .rd_regval(rv), .alu_result(alu),
        .mem_result(mem), .flush(fl), .fwd_val(fwd), .stall(stall), .stall_count(cnt)
    );

    // Saturation instance: long load latency so most cycles can stall
    logic        s_iv, s_we, s_ld, s_fl, s_rs;
    logic [4:0]  s_rd;
    logic [9:0]  s_idx;
    logic [63:0] s_rv;
    logic [31:0] s_alu, s_mem;
    logic [63:0] s_fwd;
    logic        s_stall;
    logic [15:0] s_cnt;

    bypass_scoreboard #(.XLEN(32), .NREAD(2), .DEPTH(8), .LOAD_SLOT(7)) u_sat (
        .clk(clk), .rst(s_rs), .issue_valid(s_iv), .issue_we(s_we), .issue_is_load(s_ld),
        .issue_rd(s_rd), .rd_index(s_idx), .rd_regval(s_rv), .alu_result(s_alu),
        .mem_result(s_mem), .flush(s_fl), .fwd_val(s_fwd), .stall(s_stall), .stall_count(s_cnt)
    );

    task automatic apply(input logic v, input logic w, input logic l, input logic [4:0] d,
                         input logic [4:0] i0, input logic [4:0] i1,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] a, input logic [31:0] m,
                         input logic f, input logic r);
        @(negedge clk);
        iv = v; we = w; ld = l; rd = d; idx = {i1, i0}; rv = {r1, r0};
        alu = a; mem = m; fl = f; rs = r;
        #1;
    endtask

    task automatic apply_sat(input logic v, input logic l, input logic [4:0] d,
                             input logic [4:0] i0, input logic [31:0] r0,
                             input logic [31:0] m, input logic r);
        @(negedge clk);
        s_iv = v; s_we = 1'b1; s_ld = l; s_rd = d; s_idx = {5'd1, i0};
        s_rv = {32'h0, r0}; s_alu = 32'h0; s_mem = m; s_fl = 1'b0; s_rs = r;
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        apply(1, 1, 1, 5'd4, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0);
        // Load r4 now sits in slot 0; a read of r4 would stall, but rst masks it.
        apply(1, 1, 0, 5'd6, 5'd4, 5'd4, 32'hAAAA, 32'hBBBB, 0, 0, 0, 1);
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall_during_rst: got %0b want 0", stall); end
        n_checks++; if (fwd[31:0] !== 32'hAAAA) begin n_errors++; $display("FAIL reset_fwd0_during_rst: got %h want %h", fwd[31:0], 32'hAAAA); end
        n_checks++; if (fwd[63:32] !== 32'hBBBB) begin n_errors++; $display("FAIL reset_fwd1_during_rst: got %h want %h", fwd[63:32], 32'hBBBB); end
        apply(1, 0, 0, 5'd0, 5'd4, 5'd6, 32'h1111, 32'h2222, 0, 0, 0, 0);
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall_after: got %0b want 0", stall); end
        n_checks++; if (cnt !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_checks++; if (fwd !== {32'h2222, 32'h1111}) begin n_errors++; $display("FAIL reset_fwd_after: got %h want %h", fwd, {32'h2222, 32'h1111}); end
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        apply(1, 1, 0, 5'd5, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 5'd0, 5'd5, 5'd0, 32'hDEAD, 0, 32'h1234, 0, 0, 0);
        n_checks++; if (fwd[31:0] !== 32'h1234) begin n_errors++; $display("FAIL alu_b2b_fwd: got %h want %h", fwd[31:0], 32'h1234); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL alu_b2b_stall: got %0b want 0", stall); end
        apply(1, 0, 0, 5'd0, 5'd0, 5'd5, 0, 32'hBEEF, 32'h9999, 0, 0, 0);
        n_checks++; if (fwd[63:32] !== 32'h1234) begin n_errors++; $display("FAIL alu_captured_fwd: got %h want %h", fwd[63:32], 32'h1234); end
        n_checks++; if (fwd[31:0] !== 32'h0) begin n_errors++; $display("FAIL alu_r0_port: got %h want 0", fwd[31:0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        apply(1, 1, 1, 5'd7, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 5'd8, 5'd7, 5'd3, 32'h5555, 0, 0, 0, 0, 0);
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL load_use_stall: got %0b want 1", stall); end
        apply(1, 1, 0, 5'd8, 5'd7, 5'd3, 32'h5555, 0, 0, 32'hCAFE, 0, 0);
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL load_use_release: got %0b want 0", stall); end
        n_checks++; if (fwd[31:0] !== 32'hCAFE) begin n_errors++; $display("FAIL load_use_fwd: got %h want %h", fwd[31:0], 32'hCAFE); end
        n_checks++; if (cnt !== 16'd1) begin n_errors++; $display("FAIL load_use_count: got %0d want 1", cnt); end
        apply(1, 0, 0, 5'd0, 5'd7, 5'd7, 32'h5555, 32'h6666, 0, 32'h1, 0, 0);
        n_checks++; if (fwd !== {32'hCAFE, 32'hCAFE}) begin n_errors++; $display("FAIL load_captured_fwd: got %h want %h", fwd, {32'hCAFE, 32'hCAFE}); end
    endtask

    task automatic test_priority();
        do_reset();
        apply(1, 1, 0, 5'd3, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        apply(1, 1, 0, 5'd3, 0, 0, 0, 0, 32'h11, 0, 0, 0);
        apply(1, 0, 0, 5'd0, 5'd3, 5'd3, 32'hF0, 32'hF1, 32'h22, 0, 0, 0);
        n_checks++; if (fwd[31:0] !== 32'h22) begin n_errors++; $display("FAIL prio_slot0_over_slot1: got %h want %h", fwd[31:0], 32'h22); end
        apply(1, 0, 0, 5'd0, 5'd3, 5'd3, 32'hF0, 32'hF1, 32'h77, 0, 0, 0);
        n_checks++; if (fwd !== {32'h22, 32'h22}) begin n_errors++; $display("FAIL prio_slot1_over_slot2: got %h want %h", fwd, {32'h22, 32'h22}); end
        apply(0, 0, 0, 5'd0, 5'd3, 5'd1, 32'hF0, 32'hF1, 32'h0, 0, 0, 0);
        n_checks++; if (fwd[31:0] !== 32'h22) begin n_errors++; $display("FAIL prio_last_slot: got %h want %h", fwd[31:0], 32'h22); end
        // Ready older r3 must not hide a newer unready load to r3.
        apply(1, 1, 0, 5'd3, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        apply(1, 1, 1, 5'd3, 0, 0, 0, 0, 32'h44, 0, 0, 0);
        apply(1, 0, 0, 5'd0, 5'd3, 5'd0, 0, 0, 32'h0, 0, 0, 0);
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL prio_no_mask_stall: got %0b want 1", stall); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        apply(1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'h55, 0, 0, 0);
        n_checks++; if (fwd !== 64'h0 || stall !== 1'b0) begin n_errors++; $display("FAIL r0_alu: got fwd %h stall %0b want 0 0", fwd, stall); end
        apply(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (fwd !== 64'h0 || stall !== 1'b0) begin n_errors++; $display("FAIL r0_load: got fwd %h stall %0b want 0 0", fwd, stall); end
    endtask

    task automatic test_flush();
        do_reset();
        apply(1, 1, 1, 5'd9, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 5'd4, 5'd9, 5'd1, 32'h99, 0, 0, 0, 1, 0);
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL flush_cycle_stall: got %0b want 1", stall); end
        apply(1, 1, 0, 5'd4, 5'd9, 5'd9, 32'h99, 32'h98, 0, 32'hBAD, 0, 0);
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_after_stall: got %0b want 0", stall); end
        n_checks++; if (fwd !== {32'h98, 32'h99}) begin n_errors++; $display("FAIL flush_after_fwd: got %h want %h", fwd, {32'h98, 32'h99}); end
        n_checks++; if (cnt !== 16'd1) begin n_errors++; $display("FAIL flush_count: got %0d want 1", cnt); end
        apply(1, 1, 1, 5'd10, 5'd1, 5'd2, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 5'd0, 5'd10, 5'd4, 32'hA0, 32'hA4, 32'h123, 0, 0, 0);
        n_checks++; if (stall !== 1'b0 || fwd !== {32'hA4, 32'hA0}) begin n_errors++; $display("FAIL flush_kills_issue: got fwd %h stall %0b want %h 0", fwd, stall, {32'hA4, 32'hA0}); end
    endtask

    // Reference model: list of in-flight instructions (newest first) with their age.
    typedef struct {
        bit        we;
        bit        load;
        bit [4:0]  rd;
        int        age;
        bit        known;
        bit [31:0] value;
    } m_entry_t;

    task automatic test_random();
        m_entry_t  q[$];
        int        m_cnt;
        do_reset();
        m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        v, w, l, f, r;
            logic [4:0]  d;
            logic [4:0]  ix [2];
            logic [31:0] rg [2];
            logic [31:0] a, m;
            bit          exp_stall;
            v = ($urandom % 4) != 0;
            w = ($urandom % 8) != 0;
            l = ($urandom % 3) == 0;
            d = 5'($urandom % 5);
            ix[0] = 5'($urandom % 5);
            ix[1] = 5'($urandom % 5);
            rg[0] = $urandom; rg[1] = $urandom;
            a = $urandom; m = $urandom;
            f = ($urandom % 20) == 0;
            r = ($urandom % 64) == 0;
            apply(v, w, l, d, ix[0], ix[1], rg[0], rg[1], a, m, f, r);

            exp_stall = 1'b0;
            for (int p = 0; p < 2; p++) begin
                bit        found, ok;
                bit [31:0] val;
                found = 0; ok = 1; val = rg[p];
                if (!r && ix[p] != 0) begin
                    foreach (q[j]) begin
                        if (!found && q[j].we && q[j].rd == ix[p]) begin
                            found = 1;
                            if (q[j].known) val = q[j].value;
                            else if (!q[j].load && q[j].age == 0) val = a;
                            else if (q[j].load && q[j].age == LOAD_SLOT) val = m;
                            else ok = 0;
                        end
                    end
                end
                if (!ok) exp_stall = v;
                if (ok) begin
                    n_checks++;
                    if (fwd[p*32 +: 32] !== val) begin
                        n_errors++;
                        $display("FAIL rand_fwd%0d cycle %0d: got %h want %h", p, c, fwd[p*32 +: 32], val);
                    end
                end
            end
            n_checks++;
            if (stall !== exp_stall) begin n_errors++; $display("FAIL rand_stall cycle %0d: got %0b want %0b", c, stall, exp_stall); end
            n_checks++;
            if (cnt !== 16'(m_cnt)) begin n_errors++; $display("FAIL rand_count cycle %0d: got %0d want %0d", c, cnt, m_cnt); end

            if (r) begin
                q.delete();
                m_cnt = 0;
            end else begin
                if (exp_stall && m_cnt < 65535) m_cnt++;
                if (f) begin
                    q.delete();
                end else begin
                    foreach (q[j]) begin
                        if (!q[j].known && !q[j].load && q[j].age == 0) begin q[j].known = 1; q[j].value = a; end
                        if (!q[j].known && q[j].load && q[j].age == LOAD_SLOT) begin q[j].known = 1; q[j].value = m; end
                        q[j].age++;
                    end
                    while (q.size() > 0 && q[q.size()-1].age >= DEPTH) void'(q.pop_back());
                    if (v && !exp_stall) begin
                        m_entry_t e;
                        e.we = w; e.load = l; e.rd = d; e.age = 0; e.known = 0; e.value = 0;
                        q.push_front(e);
                    end
                end
            end
        end
    endtask

    // One load to r7 every 8 cycles, re-read each cycle: 7 of 8 cycles stall.
    task automatic test_saturation();
        int exp_cnt;
        apply_sat(0, 0, 0, 0, 0, 0, 1);
        apply_sat(0, 0, 0, 0, 0, 0, 1);
        exp_cnt = 0;
        for (int per = 0; per < 9363; per++) begin
            for (int ph = 0; ph < 8; ph++) begin
                bit exp_stall;
                exp_stall = (ph != 0);
                apply_sat(1, ph == 0, 5'd7, 5'd7, 32'h7777, 32'h5000 + 32'(per), 0);
                n_checks++;
                if (s_stall !== exp_stall) begin n_errors++; $display("FAIL sat_stall per %0d ph %0d: got %0b want %0b", per, ph, s_stall, exp_stall); end
                n_checks++;
                if (s_cnt !== 16'(exp_cnt)) begin n_errors++; $display("FAIL sat_count per %0d ph %0d: got %0d want %0d", per, ph, s_cnt, exp_cnt); end
                if (ph == 0 && per > 0) begin
                    n_checks++;
                    if (s_fwd[31:0] !== 32'h5000 + 32'(per)) begin n_errors++; $display("FAIL sat_last_slot_fwd per %0d: got %h want %h", per, s_fwd[31:0], 32'h5000 + 32'(per)); end
                end
                if (exp_stall && exp_cnt < 65535) exp_cnt++;
            end
        end
        apply_sat(0, 0, 5'd0, 5'd1, 32'h0, 32'h0, 0);
        n_checks++; if (s_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_count_final: got %h want FFFF", s_cnt); end
        apply_sat(1, 1, 5'd7, 5'd1, 32'h0, 32'h0, 0);
        apply_sat(1, 0, 5'd7, 5'd7, 32'h7777, 32'h0, 1);
        n_checks++; if (s_stall !== 1'b0) begin n_errors++; $display("FAIL sat_stall_in_rst: got %0b want 0", s_stall); end
        apply_sat(1, 0, 5'd6, 5'd7, 32'h7777, 32'h0, 0);
        n_checks++; if (s_cnt !== 16'd0) begin n_errors++; $display("FAIL sat_count_after_rst: got %0d want 0", s_cnt); end
        n_checks++; if (s_stall !== 1'b0 || s_fwd[31:0] !== 32'h7777) begin n_errors++; $display("FAIL sat_slots_after_rst: got fwd %h stall %0b want 7777 0", s_fwd[31:0], s_stall); end
    endtask

    initial begin
        iv = 0; we = 0; ld = 0; rd = 0; idx = 0; rv = 0; alu = 0; mem = 0; fl = 0; rs = 1;
        s_iv = 0; s_we = 0; s_ld = 0; s_rd = 0; s_idx = 0; s_rv = 0; s_alu = 0; s_mem = 0; s_fl = 0; s_rs = 1;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_priority();
        test_reg_zero();
        test_flush();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
